uart_ram_cmd_ctrl: RTL and testbench
====================================

# uart_ram_cmd_ctrl

Command sequencer between the byte-level UART transceiver (`myUARTup`) and an on-chip RAM. It parses a small byte protocol arriving on the UART receive strobe and executes single writes, single reads, block dumps and pings against the RAM. It drives the UART transmit strobe with responses and paces them against transmitter busy. It replaces the fixed echo loop as the host-facing front end for loading and inspecting frame memory.

## Interface
- `ADDR_W`, default 12: RAM address width. The received 16-bit address is truncated to its low `ADDR_W` bits.
- `TIMEOUT`, default 1_000_000: idle clock cycles allowed between bytes of one command before it is aborted.
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in 8: received byte; valid only while `rx_valid` is high.
- `rx_valid` in 1: one-cycle pulse per received byte (UART `flagOUT_DataResive`).
- `tx_busy` in 1: UART transmitter busy. It rises the cycle after `tx_start` and falls when the stop bit completes.
- `tx_data` out 8: byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_start` out 1: one-cycle transmit request (UART `flagIN_DataRedy`).
- `ram_addr` out ADDR_W: RAM address.
- `ram_we` out 1: one-cycle write enable.
- `ram_wdata` out 8: write data.
- `ram_rdata` in 8: read data, valid one cycle after `ram_addr` is presented (synchronous RAM).
- `busy` out 1: high whenever the FSM is not in IDLE.
- `cmd_err` out 1: sticky; set by an unknown opcode or a timeout; cleared only by `rst`.

## Operation
- Commands, with the address sent high byte first:
  - `W`(0x57) aH aL d: write byte `d`; respond 0x4B.
  - `R`(0x52) aH aL: respond with one byte, `mem[a]`.
  - `D`(0x44) aH aL n: respond with n+1 bytes, `mem[a]` to `mem[a+n]`. The address wraps modulo 2^ADDR_W; n=0 gives 1 byte, n=255 gives 256 bytes.
  - `P`(0x50): respond 0x50.
  - Any other opcode: respond 0x3F, set `cmd_err`, return to IDLE.
- FSM states and transitions:
  - IDLE → OPC on `rx_valid`.
  - Argument collection: ADDR_H → ADDR_L → ARG. ARG is entered for `W` and `D` only.
  - EXEC: drives the RAM access.
  - RD_WAIT: one cycle for RAM read latency.
  - TX_REQ: waits for `tx_busy`=0, then pulses `tx_start`.
  - TX_HOLD: one cycle so the UART can raise `tx_busy`.
  - TX_WAIT: waits for `tx_busy`=0.
  - From TX_WAIT: a dump with bytes remaining goes back to EXEC with address+1 and count−1; otherwise go to IDLE.
- `rx_valid` is ignored in every state other than IDLE and argument collection. Bytes arriving during execution or response are dropped without any flag.
- Timeout: a counter is cleared on every accepted `rx_valid` and counts only in argument states. When it reaches TIMEOUT: abort to IDLE, send no response, set `cmd_err`. The counter is wide enough that it never wraps.
- Reset mid-command or mid-dump: return to IDLE immediately. Any in-flight UART byte completes on its own; the controller does not issue `tx_start` for 2 cycles after reset release.
- Reset values: `tx_start`=0, `tx_data`=0, `ram_we`=0, `ram_addr`=0, `ram_wdata`=0, `busy`=0, `cmd_err`=0, state IDLE, counters 0.

## Timing
- Let N be the cycle in which the final command byte has `rx_valid`=1.
- `W`: `ram_addr` and `ram_wdata` are valid and `ram_we`=1 in N+1 only. `tx_start` with 0x4B is at N+2 if `tx_busy`=0.
- `R`: `ram_addr` is valid from N+1 and `ram_rdata` is sampled at N+2. `tx_start` is at N+3 if idle. A busy transmitter delays `tx_start` until the first cycle with `tx_busy`=0.
- `P` and unknown opcode: `tx_start` at N+1 if `tx_busy`=0.
- `D`: the first byte follows `R` timing. Each next `ram_addr` is presented the cycle after `tx_busy` falls, giving 3 cycles of controller overhead per byte beyond UART frame time.
- `tx_start` is never high on two consecutive cycles. `ram_we` never coincides with a transmit.

## Structure
- Shared package `uart_cmd_pkg`:
  - opcode and response constants (0x57, 0x52, 0x44, 0x50, 0x4B, 0x3F);
  - the state enum.
- Natural sub-module `uart_tx_pacer`: the TX_REQ/TX_HOLD/TX_WAIT handshake. Its interface is `send`/`byte_in` → `tx_start`/`tx_data`, with a `done` pulse.
- Everything else (parser FSM, address/count registers, timeout counter) sits in the top level.

## Test plan
- `P` with `tx_busy` low → `tx_start` at N+1 with `tx_data`=0x50; `busy` is low after `tx_busy` falls.
- `W` 0x00 0x10 0xA5, then `R` 0x00 0x10 → `ram_we` pulses once at addr 0x010 with data 0xA5; responses are 0x4B, then 0xA5.
- `D` 0x0F 0xFE 0x03 with ADDR_W=12, RAM preloaded with mem[i]=i[7:0] → 4 bytes 0xFE, 0xFF, 0x00, 0x01. The address wraps 0xFFF→0x000.
- Opcode 0x13 → response 0x3F, `cmd_err`=1, and a following `P` still answers 0x50.
- `R` 0x00 then silence for TIMEOUT cycles → no `tx_start`, `cmd_err`=1, FSM in IDLE. An extra byte sent during a dump does not alter the dump output.
- `rst` asserted mid-dump after 2 of 4 bytes → no further `tx_start`, all outputs at reset values next cycle, and a following `P` is answered normally.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// Opcodes, response bytes and FSM state encoding shared by the UART
// command controller and its transmit pacer.
package uart_cmd_pkg;

  localparam logic [7:0] OPC_WRITE = 8'h57;
  localparam logic [7:0] OPC_READ  = 8'h52;
  localparam logic [7:0] OPC_DUMP  = 8'h44;
  localparam logic [7:0] OPC_PING  = 8'h50;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  typedef enum logic [3:0] {
    IDLE,
    OPC,
    ADDR_H,
    ADDR_L,
    ARG,
    EXEC,
    RD_WAIT,
    TX_REQ,
    TX_HOLD,
    TX_WAIT
  } state_e;

  // Opcodes that carry an address and therefore enter argument collection.
  function automatic logic has_addr(input logic [7:0] op);
    return (op == OPC_WRITE) || (op == OPC_READ) || (op == OPC_DUMP);
  endfunction

endpackage

// File: rtl/uart_tx_pacer.sv
// Hands one byte to the UART transmitter: waits for it to be free, pulses
// tx_start, then reports done once the frame has gone out.
module uart_tx_pacer
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] byte_in,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       done
);

  state_e     state_q, state_d;
  logic [7:0] data_q;
  logic [1:0] guard_q;
  logic       launch_ok;

  // guard_q keeps the transmitter quiet for the first two cycles after reset.
  assign launch_ok = !tx_busy && (guard_q == 2'd2);

  always_comb begin
    state_d  = state_q;
    tx_start = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (send) begin
          if (launch_ok) begin
            tx_start = 1'b1;
            state_d  = TX_HOLD;
          end else begin
            state_d = TX_REQ;
          end
        end
      end
      TX_REQ: begin
        if (launch_ok) begin
          tx_start = 1'b1;
          state_d  = TX_HOLD;
        end
      end
      TX_HOLD: state_d = TX_WAIT;
      TX_WAIT: begin
        if (!tx_busy) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      guard_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && send) data_q <= byte_in;
      if (guard_q != 2'd2) guard_q <= guard_q + 2'd1;
    end
  end

  // A launch straight from IDLE must show the byte in the same cycle.
  assign tx_data = (state_q == IDLE) ? byte_in : data_q;

endmodule

// File: rtl/uart_ram_cmd_ctrl.sv
// Byte-protocol command sequencer: parses W/R/D/P commands from the UART
// receiver, drives the RAM and returns responses through the tx pacer.
module uart_ram_cmd_ctrl
  import uart_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_busy,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int unsigned     TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [7:0]        op_q, op_d, ah_q, ah_d, cnt_q, cnt_d;
  logic [7:0]        wdata_q, wdata_d, resp_q, resp_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic              err_q, err_d;
  logic              send, done, arg_state;

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ah_d      = ah_q;
    cnt_d     = cnt_q;
    wdata_d   = wdata_q;
    resp_d    = resp_q;
    addr_d    = addr_q;
    err_d     = err_q;
    send      = 1'b0;
    arg_state = state_q inside {ADDR_H, ADDR_L, ARG};
    tmo_d     = (arg_state && !rx_valid) ? tmo_q + 1'b1 : '0;

    case (state_q)
      IDLE: begin
        if (rx_valid) begin
          op_d    = rx_data;
          resp_d  = (rx_data == OPC_PING) ? OPC_PING : RSP_ERR;
          state_d = OPC;
        end
      end
      OPC: begin
        if (has_addr(op_q)) begin
          state_d = ADDR_H;
        end else begin
          // Ping and unknown opcodes answer immediately with the byte staged in IDLE.
          send    = 1'b1;
          err_d   = err_q | (op_q != OPC_PING);
          state_d = TX_WAIT;
        end
      end
      ADDR_H: begin
        if (rx_valid) begin
          ah_d    = rx_data;
          state_d = ADDR_L;
        end
      end
      ADDR_L: begin
        if (rx_valid) begin
          addr_d  = ADDR_W'({ah_q, rx_data});
          state_d = (op_q == OPC_READ) ? EXEC : ARG;
        end
      end
      ARG: begin
        if (rx_valid) begin
          wdata_d = rx_data;
          cnt_d   = rx_data;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (op_q == OPC_WRITE) begin
          resp_d  = RSP_ACK;
          state_d = TX_REQ;
        end else begin
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        resp_d  = ram_rdata;
        state_d = TX_REQ;
      end
      TX_REQ: begin
        send    = 1'b1;
        state_d = TX_WAIT;
      end
      TX_WAIT: begin
        if (done) begin
          if (op_q == OPC_DUMP && cnt_q != '0) begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = EXEC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (arg_state && !rx_valid && tmo_q == TMO_LAST) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      ah_q    <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      addr_q  <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ah_q    <= ah_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      resp_q  <= resp_d;
      addr_q  <= addr_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  uart_tx_pacer u_pacer (
    .clk     (clk),
    .rst     (rst),
    .send    (send),
    .byte_in (resp_q),
    .tx_busy (tx_busy),
    .tx_start(tx_start),
    .tx_data (tx_data),
    .done    (done)
  );

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_we    = (state_q == EXEC) && (op_q == OPC_WRITE);
  assign busy      = (state_q != IDLE);
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_uart_ram_cmd_ctrl.sv
// Directed bench for uart_ram_cmd_ctrl with a synchronous RAM and a simple
// UART transmitter model whose frame lasts FRAME cycles.
module tb_uart_ram_cmd_ctrl;

  localparam int unsigned ADDR_W = 12;
  localparam int          TMO    = 40;
  localparam int          FRAME  = 12;

  logic              clk      = 1'b0;
  logic              rst      = 1'b1;
  logic [7:0]        rx_data  = '0;
  logic              rx_valid = 1'b0;
  logic              tx_busy  = 1'b0;
  logic [7:0]        ram_rdata = '0;
  logic [7:0]        tx_data;
  logic              tx_start;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_wdata;
  logic              busy;
  logic              cmd_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int viol   = 0;
  int txcnt  = 0;
  logic prev_start = 1'b0;

  logic [7:0]        mem [0:(1<<ADDR_W)-1];
  logic [7:0]        tx_bytes[$];
  int                tx_cycs[$];
  logic [ADDR_W-1:0] we_addrs[$];
  logic [7:0]        we_datas[$];
  int                we_cycs[$];

  uart_ram_cmd_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_busy  (tx_busy),
    .tx_data  (tx_data),
    .tx_start (tx_start),
    .ram_addr (ram_addr),
    .ram_we   (ram_we),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i);

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Transmitter: busy from the cycle after tx_start for FRAME cycles.
  always @(posedge clk) begin
    if (tx_start) begin
      tx_busy <= 1'b1;
      txcnt   <= FRAME;
    end else if (txcnt != 0) begin
      txcnt <= txcnt - 1;
      if (txcnt == 1) tx_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_start) begin
      tx_bytes.push_back(tx_data);
      tx_cycs.push_back(cyc);
      if (tx_busy || prev_start || ram_we) viol++;
    end
    if (ram_we) begin
      we_addrs.push_back(ram_addr);
      we_datas.push_back(ram_wdata);
      we_cycs.push_back(cyc);
    end
    prev_start = tx_start;
  end

  task automatic send_byte(input logic [7:0] b, output int n);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    n        = cyc;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic wait_tx(input int target, input int budget);
    int k = 0;
    while (tx_bytes.size() < target && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((busy || tx_busy) && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data, ram_we, ram_addr, ram_wdata, busy, cmd_err} !== '0) begin
      errors++;
      $display("FAIL reset_values: got %h required 0",
               {tx_start, tx_data, ram_we, ram_addr, ram_wdata, busy, cmd_err});
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_ping();
    int n, k, base;
    base = tx_bytes.size();
    send_byte(8'h50, n);
    wait_tx(base + 1, 50);
    checks++;
    if (tx_bytes.size() !== base + 1) begin
      errors++;
      $display("FAIL ping_count: got %0d required %0d", tx_bytes.size(), base + 1);
    end else begin
      checks++;
      if (tx_bytes[base] !== 8'h50) begin
        errors++;
        $display("FAIL ping_byte: got %h required 50", tx_bytes[base]);
      end
      checks++;
      if (tx_cycs[base] !== n + 1) begin
        errors++;
        $display("FAIL ping_latency: got %0d required %0d", tx_cycs[base] - n, 1);
      end
    end
    @(negedge clk);
    k = 0;
    while (tx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ping_busy_after: got %b required 0", busy);
    end
  endtask

  task automatic test_write_read();
    int n, base, wbase;
    base  = tx_bytes.size();
    wbase = we_addrs.size();
    send_byte(8'h57, n);
    send_byte(8'h00, n);
    send_byte(8'h10, n);
    send_byte(8'hA5, n);
    wait_tx(base + 1, 50);
    checks++;
    if (tx_bytes.size() !== base + 1 || tx_bytes[base] !== 8'h4B || tx_cycs[base] !== n + 2) begin
      errors++;
      $display("FAIL write_resp: got count %0d byte %h lat %0d required %0d 4b 2",
               tx_bytes.size(), tx_bytes[base], tx_cycs[base] - n, base + 1);
    end
    checks++;
    if (we_addrs.size() !== wbase + 1) begin
      errors++;
      $display("FAIL write_we_count: got %0d required %0d", we_addrs.size(), wbase + 1);
    end else begin
      checks++;
      if (we_addrs[wbase] !== 12'h010 || we_datas[wbase] !== 8'hA5 || we_cycs[wbase] !== n + 1) begin
        errors++;
        $display("FAIL write_we: got addr %h data %h lat %0d required 010 a5 1",
                 we_addrs[wbase], we_datas[wbase], we_cycs[wbase] - n);
      end
    end
    wait_idle(200);
    send_byte(8'h52, n);
    send_byte(8'h00, n);
    send_byte(8'h10, n);
    wait_tx(base + 2, 50);
    checks++;
    if (tx_bytes.size() !== base + 2 || tx_bytes[base+1] !== 8'hA5 || tx_cycs[base+1] !== n + 3) begin
      errors++;
      $display("FAIL read_resp: got count %0d byte %h lat %0d required %0d a5 3",
               tx_bytes.size(), tx_bytes[base+1], tx_cycs[base+1] - n, base + 2);
    end
    checks++;
    if (we_addrs.size() !== wbase + 1) begin
      errors++;
      $display("FAIL read_no_we: got %0d required %0d", we_addrs.size(), wbase + 1);
    end
    wait_idle(200);
  endtask

  task automatic test_dump_wrap(input logic inject);
    int n, dummy, base;
    logic [7:0] exp [4];
    exp  = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    base = tx_bytes.size();
    send_byte(8'h44, n);
    send_byte(8'h0F, n);
    send_byte(8'hFE, n);
    send_byte(8'h03, n);
    if (inject) begin
      wait_tx(base + 1, 50);
      send_byte(8'h50, dummy);
    end
    wait_tx(base + 4, 400);
    wait_idle(200);
    repeat (2 * FRAME) @(negedge clk);
    checks++;
    if (tx_bytes.size() !== base + 4) begin
      errors++;
      $display("FAIL dump_count(inject=%0b): got %0d required %0d", inject, tx_bytes.size(), base + 4);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (tx_bytes[base+i] !== exp[i]) begin
          errors++;
          $display("FAIL dump_byte%0d(inject=%0b): got %h required %h", i, inject, tx_bytes[base+i], exp[i]);
        end
      end
      checks++;
      if (tx_cycs[base] !== n + 3) begin
        errors++;
        $display("FAIL dump_first_latency: got %0d required 3", tx_cycs[base] - n);
      end
      checks++;
      if (tx_cycs[base+1] - tx_cycs[base] !== FRAME + 4) begin
        errors++;
        $display("FAIL dump_gap: got %0d required %0d", tx_cycs[base+1] - tx_cycs[base], FRAME + 4);
      end
    end
  endtask

  task automatic test_reset_mid_dump();
    int n, k, base;
    base = tx_bytes.size();
    send_byte(8'h44, n);
    send_byte(8'h0F, n);
    send_byte(8'hFE, n);
    send_byte(8'h03, n);
    wait_tx(base + 2, 400);
    pulse_reset();
    @(negedge clk);
    checks++;
    if ({tx_start, tx_data, ram_we, ram_addr, ram_wdata, busy, cmd_err} !== '0) begin
      errors++;
      $display("FAIL midreset_values: got %h required 0",
               {tx_start, tx_data, ram_we, ram_addr, ram_wdata, busy, cmd_err});
    end
    repeat (4 * FRAME) @(negedge clk);
    checks++;
    if (tx_bytes.size() !== base + 2) begin
      errors++;
      $display("FAIL midreset_no_tx: got %0d required %0d", tx_bytes.size(), base + 2);
    end
    k = 0;
    while (tx_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    send_byte(8'h50, n);
    wait_tx(base + 3, 50);
    checks++;
    if (tx_bytes.size() !== base + 3 || tx_bytes[base+2] !== 8'h50) begin
      errors++;
      $display("FAIL midreset_ping: got count %0d byte %h required %0d 50",
               tx_bytes.size(), tx_bytes[base+2], base + 3);
    end
    wait_idle(200);
  endtask

  task automatic test_timeout();
    int n, base;
    base = tx_bytes.size();
    send_byte(8'h52, n);
    send_byte(8'h00, n);
    while (cyc < n + TMO - 2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got busy %b err %b required 1 0", busy, cmd_err);
    end
    while (cyc < n + TMO + 2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_abort: got busy %b err %b required 0 1", busy, cmd_err);
    end
    checks++;
    if (tx_bytes.size() !== base) begin
      errors++;
      $display("FAIL timeout_no_tx: got %0d required %0d", tx_bytes.size(), base);
    end
  endtask

  task automatic test_unknown_opcode();
    int n, base;
    pulse_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_err !== 1'b0) begin
      errors++;
      $display("FAIL err_cleared: got %b required 0", cmd_err);
    end
    base = tx_bytes.size();
    send_byte(8'h13, n);
    wait_tx(base + 1, 50);
    checks++;
    if (tx_bytes.size() !== base + 1 || tx_bytes[base] !== 8'h3F || tx_cycs[base] !== n + 1) begin
      errors++;
      $display("FAIL unknown_resp: got count %0d byte %h lat %0d required %0d 3f 1",
               tx_bytes.size(), tx_bytes[base], tx_cycs[base] - n, base + 1);
    end
    wait_idle(200);
    checks++;
    if (cmd_err !== 1'b1) begin
      errors++;
      $display("FAIL unknown_err: got %b required 1", cmd_err);
    end
    send_byte(8'h50, n);
    wait_tx(base + 2, 50);
    checks++;
    if (tx_bytes.size() !== base + 2 || tx_bytes[base+1] !== 8'h50) begin
      errors++;
      $display("FAIL unknown_then_ping: got count %0d byte %h required %0d 50",
               tx_bytes.size(), tx_bytes[base+1], base + 2);
    end
    wait_idle(200);
  endtask

  task automatic test_protocol();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL tx_protocol: got %0d violations required 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_ping();
    test_write_read();
    test_dump_wrap(1'b0);
    test_dump_wrap(1'b1);
    test_reset_mid_dump();
    test_timeout();
    test_unknown_opcode();
    test_protocol();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
